result_packer: RTL and testbench
================================

// Module: result_packer
// PURPOSE
//  Parametrised successor to the 2-slot result buffer. Packs a stream of DATA_W-bit
//  ALU results into WORD_W-bit memory words (LANES = WORD_W/DATA_W slots per word).
//  Completed or flushed words go into a DEPTH-entry first-word-fall-through FIFO.
//  Sits between the ALU result path and the memory write controller; valid/ready on both sides.
// PARAMETERS
//  DATA_W  32  result width; WORD_W % DATA_W == 0 required
//  WORD_W  64  packed word width (MEM_WORD_SIZE); LANES = WORD_W/DATA_W >= 2
//  DEPTH    4  output FIFO entries, >= 1; pointers wrap DEPTH-1 -> 0
// PORTS
//  clk_i          in   1                 clock, all state on posedge
//  rst_ni         in   1                 synchronous reset, active-low
//  result_i       in   DATA_W            result from ALU
//  result_valid_i in   1                 result_i valid
//  result_ready_o out  1                 packer can accept result_i
//  flush_i        in   1                 1-cycle pulse: emit partial word
//  word_o         out  WORD_W            FIFO head word
//  word_mask_o    out  LANES             head word lane-valid mask, bit k = lane k
//  word_valid_o   out  1                 FIFO non-empty
//  word_ready_i   in   1                 consumer takes head this cycle
//  fifo_count_o   out  $clog2(DEPTH+1)   FIFO occupancy
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): lane_idx=0, assembly reg=0, mask=0, state=FILL, FIFO empty.
//    Outputs: word_valid_o=0, word_o=0, word_mask_o=0, fifo_count_o=0, result_ready_o=0 while
//    rst_ni=0. Reset mid-word discards the partial word and all FIFO contents.
//  - Lane k occupies word bits [k*DATA_W +: DATA_W]. Lane 0 is the LSBs and is filled first.
//  - Accept = result_valid_i & result_ready_o. On accept: write lane lane_idx, set mask bit,
//    lane_idx++.
//  - Completing lane LANES-1 pushes {assembly, mask} to the FIFO in the same cycle.
//    The assembly reg and mask clear to 0 and lane_idx wraps to 0.
//  - Unfilled lanes of any pushed word are zero.
//  - result_ready_o = rst_ni & (state==FILL) & ~(fifo_full & lane_idx==LANES-1).
//    No combinational path from word_ready_i to result_ready_o.
//  - FSM:
//    - FILL: flush_i with (lane_idx!=0 or accept): if FIFO not full, push partial word
//      (including a same-cycle accepted result) and clear; else -> FLUSH_WAIT.
//      flush_i with lane_idx==0 and no accept: no-op.
//    - FLUSH_WAIT: result_ready_o=0. Push partial word the first cycle FIFO not full
//      -> FILL. Further flush_i pulses are ignored.
//  - "FIFO not full" is evaluated on the registered count; a same-cycle pop does not enable
//    a push when full.
//  - FIFO: FWFT. Pop = word_valid_o & word_ready_i. Simultaneous push+pop when
//    0 < count < DEPTH leaves count unchanged.
//  - word_ready_i while empty is ignored. word_o/word_mask_o read 0 when empty.
//  - Latency: push on the posedge of the completing accept; word_valid_o is high the
//    following cycle.
// CONFIGURATION
//  RESULT_PACKER_STATS_EN defined:
//    - adds outputs words_out_o [31:0] (count of pops) and partial_out_o [31:0]
//      (count of pushes with mask != all-ones);
//    - both reset to 0 and wrap 2^32-1 -> 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (DATA_W=32, WORD_W=64, DEPTH=2 unless stated)
//  1. Reset: rst_ni=0 for 2 cycles with valid=1 -> ready=0, word_valid=0, count=0.
//  2. Pack: accept 0x1111_1111 then 0x2222_2222, word_ready_i=0 -> next cycle
//     word_o=0x2222_2222_1111_1111, mask=2'b11, count=1.
//  3. Flush partial: accept 0xAAAA_AAAA, then flush_i ->
//     word_o=0x0000_0000_AAAA_AAAA, mask=2'b01.
//     Flush with lane_idx=0 -> no push.
//  4. Backpressure: word_ready_i=0, push 2 words (count=2), send lane 0 -> accepted;
//     lane 1 -> ready=0 until one pop, then accepted; order preserved.
//  5. Flush while full: count=2, lane_idx=1, flush_i -> FLUSH_WAIT, ready=0, further
//     flushes ignored; after pop the partial word pushes with mask=2'b01, back to FILL.
//  6. Reset mid-word plus LANES=4 (WORD_W=128): accept 3 results, pulse rst_ni=0 ->
//     FIFO empty; next 4 results form one word with mask=4'b1111.

Source files
------------

// File: rtl/result_packer.sv
// result_packer: packs DATA_W-bit ALU results into WORD_W-bit memory words
// (LANES = WORD_W/DATA_W slots, lane 0 in the LSBs) and queues finished or
// flushed words in a DEPTH-entry first-word-fall-through FIFO.
// Optional: define RESULT_PACKER_STATS_EN to add pop / partial-push counters.

// One assembly slot: holds a result and its valid bit, and exposes the value
// the slot will hold after this cycle's write so a same-cycle push sees it.
module result_packer_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] data_nxt_o,
    output logic              vld_nxt_o
);
    logic [DATA_W-1:0] data_q;
    logic              vld_q;

    assign data_nxt_o = wr_i ? din_i : data_q;
    assign vld_nxt_o  = wr_i | vld_q;

    // Slot storage; clear wins because a push already carries the write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (clr_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (wr_i) begin
            data_q <= din_i;
            vld_q  <= 1'b1;
        end
    end
endmodule

module result_packer #(
    parameter int DATA_W = 32,
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [DATA_W-1:0]                result_i,
    input  logic                             result_valid_i,
    output logic                             result_ready_o,
    input  logic                             flush_i,
    output logic [WORD_W-1:0]                word_o,
    output logic [WORD_W/DATA_W-1:0]         word_mask_o,
    output logic                             word_valid_o,
    input  logic                             word_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]       fifo_count_o
`ifdef RESULT_PACKER_STATS_EN
    ,
    output logic [31:0]                      words_out_o,
    output logic [31:0]                      partial_out_o
`endif
);
    localparam int LANES  = WORD_W / DATA_W;
    localparam int LIDX_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {FILL = 1'b0, FLUSH_WAIT = 1'b1} state_t;

    state_t                          state_q;
    logic [LIDX_W-1:0]               lane_idx_q;
    logic [CNT_W-1:0]                count_q;
    logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
    logic [WORD_W-1:0]               mem_word [DEPTH];
    logic [LANES-1:0]                mem_mask [DEPTH];

    logic [LANES-1:0][DATA_W-1:0]    nxt_data;
    logic [LANES-1:0]                nxt_mask;
    logic [LANES-1:0]                lane_wr;
    logic                            fifo_full, last_lane, accept, flush_hit;
    logic                            push, pop, go_wait;

    assign fifo_full      = (count_q == CNT_W'(DEPTH));
    assign last_lane      = (lane_idx_q == LIDX_W'(LANES - 1));
    // Depends only on registered state, never on word_ready_i.
    assign result_ready_o = rst_ni & (state_q == FILL) & ~(fifo_full & last_lane);
    assign accept         = result_valid_i & result_ready_o;
    assign flush_hit      = flush_i & ((lane_idx_q != '0) | accept);
    // A completing accept can only happen when the FIFO has room.
    assign push    = (state_q == FILL) ? ((accept & last_lane) | (flush_hit & ~fifo_full))
                                       : ~fifo_full;
    assign go_wait = (state_q == FILL) & flush_hit & fifo_full;
    assign pop     = (count_q != '0) & word_ready_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_wr[k] = accept & (lane_idx_q == LIDX_W'(k));
        result_packer_lane #(.DATA_W(DATA_W)) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wr_i       (lane_wr[k]),
            .clr_i      (push),
            .din_i      (result_i),
            .data_nxt_o (nxt_data[k]),
            .vld_nxt_o  (nxt_mask[k])
        );
    end

    // Packing FSM: lane index and flush-wait tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= FILL;
            lane_idx_q <= '0;
        end else begin
            if (push)
                lane_idx_q <= '0;
            else if (accept)
                lane_idx_q <= lane_idx_q + LIDX_W'(1);
            case (state_q)
                FILL:       if (go_wait) state_q <= FLUSH_WAIT;
                FLUSH_WAIT: if (push)    state_q <= FILL;
                default:    state_q <= FILL;
            endcase
        end
    end

    // FIFO storage; entries need no reset since empty reads are forced to 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_word[wr_ptr_q] <= WORD_W'(nxt_data);
            mem_mask[wr_ptr_q] <= nxt_mask;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign word_valid_o = (count_q != '0);
    assign word_o       = word_valid_o ? mem_word[rd_ptr_q] : '0;
    assign word_mask_o  = word_valid_o ? mem_mask[rd_ptr_q] : '0;
    assign fifo_count_o = count_q;

`ifdef RESULT_PACKER_STATS_EN
    // Wrapping statistics: words consumed and words pushed with empty lanes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            words_out_o   <= '0;
            partial_out_o <= '0;
        end else begin
            if (pop)
                words_out_o <= words_out_o + 32'd1;
            if (push && !(&nxt_mask))
                partial_out_o <= partial_out_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: 2-lane/depth-2 instance for the main
// scenarios, 4-lane/depth-2 instance for mid-word reset and wide packing.
module tb_result_packer;
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 2-lane instance
    logic         rst_n, valid, flush, wready, ready, wvalid;
    logic [31:0]  res;
    logic [63:0]  word;
    logic [1:0]   mask, cnt;
    // 4-lane instance
    logic         rst4_n, valid4, flush4, wready4, ready4, wvalid4;
    logic [31:0]  res4;
    logic [127:0] word4;
    logic [3:0]   mask4;
    logic [1:0]   cnt4;
`ifdef RESULT_PACKER_STATS_EN
    logic [31:0]  wo, po, wo4, po4;
`endif

    result_packer #(.DATA_W(32), .WORD_W(64), .DEPTH(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .result_i(res), .result_valid_i(valid),
        .result_ready_o(ready), .flush_i(flush), .word_o(word), .word_mask_o(mask),
        .word_valid_o(wvalid), .word_ready_i(wready), .fifo_count_o(cnt)
`ifdef RESULT_PACKER_STATS_EN
        , .words_out_o(wo), .partial_out_o(po)
`endif
    );

    result_packer #(.DATA_W(32), .WORD_W(128), .DEPTH(2)) u_dut4 (
        .clk_i(clk), .rst_ni(rst4_n), .result_i(res4), .result_valid_i(valid4),
        .result_ready_o(ready4), .flush_i(flush4), .word_o(word4), .word_mask_o(mask4),
        .word_valid_o(wvalid4), .word_ready_i(wready4), .fifo_count_o(cnt4)
`ifdef RESULT_PACKER_STATS_EN
        , .words_out_o(wo4), .partial_out_o(po4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        res = d; valid = 1'b1; tick(); valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d);
        res4 = d; valid4 = 1'b1; tick(); valid4 = 1'b0;
    endtask

    task automatic pop1();
        wready = 1'b1; tick(); wready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b1; flush = 1'b0; wready = 1'b0; res = 32'hDEAD_BEEF;
        rst4_n = 1'b0; valid4 = 1'b0; flush4 = 1'b0; wready4 = 1'b0; res4 = '0;

        // 1. reset with valid asserted
        tick(); tick();
        chk("rst_ready",  ready,  1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_count",  cnt,    2'd0);
        chk("rst_word",   word,   64'h0);
        chk("rst_mask",   mask,   2'b00);
        rst_n = 1'b1; rst4_n = 1'b1; valid = 1'b0;
        tick();

        // 2. pack two results
        res = 32'h1111_1111; valid = 1'b1; #1;
        chk("pack_ready", ready, 1'b1);
        tick();
        res = 32'h2222_2222; tick(); valid = 1'b0;
        chk("pack_wvalid", wvalid, 1'b1);
        chk("pack_word",   word,   64'h2222_2222_1111_1111);
        chk("pack_mask",   mask,   2'b11);
        chk("pack_count",  cnt,    2'd1);
        pop1();
        chk("pack_pop_count", cnt,  2'd0);
        chk("empty_word",     word, 64'h0);

        // 3. flush partial word
        send(32'hAAAA_AAAA);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_word",  word, 64'h0000_0000_AAAA_AAAA);
        chk("flush_mask",  mask, 2'b01);
        chk("flush_count", cnt,  2'd1);
        pop1();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_idle_count",  cnt,    2'd0);
        chk("flush_idle_wvalid", wvalid, 1'b0);
        res = 32'hBBBB_BBBB; valid = 1'b1; flush = 1'b1; tick(); valid = 1'b0; flush = 1'b0;
        chk("flush_acc_word", word, 64'h0000_0000_BBBB_BBBB);
        chk("flush_acc_mask", mask, 2'b01);
        pop1();

        // 4. backpressure
        send(32'h1); send(32'h2); send(32'h3); send(32'h4);
        chk("bp_count_full", cnt, 2'd2);
        res = 32'h5; valid = 1'b1; #1;
        chk("bp_lane0_ready", ready, 1'b1);
        tick();
        res = 32'h6; #1;
        chk("bp_lane1_ready", ready, 1'b0);
        tick();
        chk("bp_stall_count", cnt,   2'd2);
        chk("bp_head0",       word,  64'h2_0000_0001);
        wready = 1'b1; #1;
        chk("bp_no_comb_path", ready, 1'b0);
        tick(); wready = 1'b0; #1;
        chk("bp_ready_after_pop", ready, 1'b1);
        tick(); valid = 1'b0;
        chk("bp_count_refill", cnt,  2'd2);
        chk("bp_head1",        word, 64'h4_0000_0003);
        pop1();
        chk("bp_head2", word, 64'h6_0000_0005);
        chk("bp_mask2", mask, 2'b11);
        pop1();

        // 5. flush while full
        send(32'h10); send(32'h11); send(32'h12); send(32'h13);
        send(32'h14);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fw_ready", ready, 1'b0);
        chk("fw_count", cnt,   2'd2);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fw_ignored_count", cnt, 2'd2);
        pop1();
        chk("fw_pop_count", cnt,   2'd1);
        chk("fw_pop_ready", ready, 1'b0);
        tick();
        chk("fw_push_count", cnt,   2'd2);
        chk("fw_back_fill",  ready, 1'b1);
        chk("fw_head0",      word,  64'h13_0000_0012);
        pop1();
        chk("fw_partial_word", word, 64'h0000_0000_0000_0014);
        chk("fw_partial_mask", mask, 2'b01);
        pop1();
        tick();
        chk("fw_drained", cnt, 2'd0);

        // 6. 4-lane: reset mid-word, then a full word and a partial word
        send4(32'h1); send4(32'h2); send4(32'h3); send4(32'h4);
        chk("l4_pre_count", cnt4, 2'd1);
        send4(32'hA1); send4(32'hA2); send4(32'hA3);
        rst4_n = 1'b0; tick(); #1;
        chk("l4_rst_count",  cnt4,   2'd0);
        chk("l4_rst_wvalid", wvalid4, 1'b0);
        chk("l4_rst_ready",  ready4,  1'b0);
        rst4_n = 1'b1;
        send4(32'h5); send4(32'h6); send4(32'h7);
        chk("l4_no_early_push", cnt4, 2'd0);
        send4(32'h8);
        chk("l4_word",  word4, 128'h0000_0008_0000_0007_0000_0006_0000_0005);
        chk("l4_mask",  mask4, 4'b1111);
        chk("l4_count", cnt4,  2'd1);
        wready4 = 1'b1; tick(); wready4 = 1'b0;
        send4(32'h9); send4(32'hA);
        flush4 = 1'b1; tick(); flush4 = 1'b0;
        chk("l4_part_word", word4, 128'h0000_000A_0000_0009);
        chk("l4_part_mask", mask4, 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
